periph_bus_slave: RTL and testbench
===================================

# periph_bus_slave

Memory-mapped peripheral responder on the CPU's peripheral bus. It is the target side of the bus where the CPU drives the read strobe, the peripheral write strobe, the ALU-computed address and the write data, and samples the read data. It implements a reloadable 32-bit timer that raises the CPU's IRQ line, an LED output register, a switch input port and a 7-segment digit register. An optional free-running system tick counter can be compiled in.

## Interface
- `TIMER_RESET_TH`, default 32'hFFFF_FC00; reset value of TH.
- `TIMER_RESET_TL`, default 32'hFFFF_FC00; reset value of TL.
- `clk` in 1: system clock, the same clock as the CPU.
- `reset` in 1: asynchronous, active-high reset.
- `rd` in 1: read strobe (CPU MemRead).
- `wr` in 1: write strobe (CPU PerWr).
- `addr` in 32: byte address. Decode uses addr[31:2]; addr[1:0] is ignored.
- `wdata` in 32: write data.
- `rdata` out 32: read data, combinational.
- `switch` in 8: board switches, asynchronous.
- `led` out 8: LED register.
- `digi` out 12: 7-segment register, {anode[3:0], seg[7:0]}.
- `irqout` out 1: interrupt request to the CPU; equals TCON[2].

## Operation
- Register map, word addresses:
  - 0x4000_0000: TH, R/W, 32 bits.
  - 0x4000_0004: TL, R/W, 32 bits.
  - 0x4000_0008: TCON, R/W, bits [2:0] only; upper bits read 0. Bit 0 is timer enable, bit 1 is IRQ enable, bit 2 is IRQ status.
  - 0x4000_000C: LED, R/W, 8 bits.
  - 0x4000_0010: switch, read-only; writes are ignored.
  - 0x4000_0014: digi, R/W, 12 bits.
  - 0x4000_0018: SYSTICK, read-only (see Configuration).
- Unmapped addresses read 0; writes to them are ignored.
- Narrow registers zero-extend on read and use only the low bits of `wdata` on write.
- `rdata` is the selected register when `rd`=1, else 32'h0.
- A write takes effect at the posedge where `wr`=1.
- If `rd` and `wr` are both asserted, the read returns the old value and the write proceeds.
- Timer, each cycle with TCON[0]=1:
  - If TL == 32'hFFFF_FFFF, then TL <= TH on that edge, and if TCON[1]=1, TCON[2] <= 1 on the same edge.
  - Otherwise TL <= TL + 1, modulo 2^32.
- TCON[0]=0 freezes TL. TCON[2] remains sticky until software writes 0 to it.
- `switch` is passed through a 2-flop synchronizer before it is read.

## Timing
- Reset values:
  - TH = TIMER_RESET_TH, TL = TIMER_RESET_TL.
  - TCON = 0, led = 0, digi = 12'h000, SYSTICK = 0.
  - irqout = 0, rdata = 0.
- Read latency is 0 cycles (combinational from `addr`/`rd`).
- Write latency is 1 edge; the written value is visible on `rdata` in the next cycle.
- The switch value read reflects the pin state 2 edges earlier.
- irqout rises on the same edge that reloads TL. It falls on the edge where software clears TCON[2], or when reset asserts.
- Simultaneous events:
  - CPU write to TL on an increment or overflow edge: the written value wins. No reload occurs, and TCON[2] is not set by that edge.
  - CPU write to TH on an overflow edge: the reload uses the old TH.
  - CPU write to TCON on an overflow edge with TCON[1]=1: bits [1:0] take `wdata`. Bit 2 is set to 1 regardless of `wdata`, so no interrupt is lost.
- Reset asserted mid-count returns every register to its reset value immediately, without waiting for a clock edge.

## Configuration
- `PERIPH_SYSTICK_EN` defined:
  - SYSTICK is a 32-bit counter, incremented every cycle from reset and wrapping 32'hFFFF_FFFF -> 0.
  - It is readable at 0x4000_0018.
- `PERIPH_SYSTICK_EN` undefined:
  - No counter is instantiated.
  - 0x4000_0018 is treated as unmapped and reads 0.

## Test plan
- **Reset readback:** assert reset, release, then read 0x4000_0000/04/08. Expect 32'hFFFF_FC00, 32'hFFFF_FC00, 0, with irqout=0.
- **Overflow and IRQ:**
  - Write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3.
  - Two edges later, TL=32'hFFFF_FFF0 and irqout=1.
  - Write TCON=3: irqout=0 on the next cycle, and the count continues.
- **Collision:** TL=32'hFFFF_FFFF with TCON=3, and write TCON=32'h1 on that edge. Expect TCON reads 5 and irqout=1.
- **LED/digi/switch:**
  - Write LED=32'h1A5: led=8'hA5, and a read returns 32'h0000_00A5.
  - Write digi=32'hFFF: digi=12'hFFF.
  - Drive switch=8'h3C: a read of 0x4000_0010 returns 32'h3C no earlier than 2 edges later.
- **Unmapped and strobes:**
  - Read 0x4000_0020: returns 0.
  - Write 0x4000_0010: no effect.
  - rd=0 at a valid address: rdata=0.
- **SYSTICK, both builds:**
  - With `PERIPH_SYSTICK_EN`, reads 10 edges apart differ by 10.
  - Without it, 0x4000_0018 reads 0.

Source files
------------

// File: rtl/periph_bus_slave_if.sv
// CPU peripheral bus: read/write strobes, byte address, write data and combinational read data.
interface periph_bus_slave_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/periph_bus_slave.sv
// Peripheral target: reloadable timer with IRQ, LED/digi registers, synced switches; SYSTICK if PERIPH_SYSTICK_EN.
// Latency: reads are combinational (0 cycles); writes commit on the clock edge where wr is high.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module periph_bus_slave #(
  parameter logic [31:0] TIMER_RESET_TH = 32'hFFFF_FC00,
  parameter logic [31:0] TIMER_RESET_TL = 32'hFFFF_FC00
) (
  input  logic               clk,
  input  logic               reset,
  periph_bus_slave_if.slave  bus,
  input  logic [7:0]         switch,
  output logic [7:0]         led,
  output logic [11:0]        digi,
  output logic               irqout
);
  localparam logic [29:0] WA_TH   = 30'h1000_0000;
  localparam logic [29:0] WA_TL   = 30'h1000_0001;
  localparam logic [29:0] WA_TCON = 30'h1000_0002;
  localparam logic [29:0] WA_LED  = 30'h1000_0003;
  localparam logic [29:0] WA_SW   = 30'h1000_0004;
  localparam logic [29:0] WA_DIGI = 30'h1000_0005;

  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [7:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [29:0] word;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi, ovf;
  logic [31:0] rdata_c;
  logic        unused_addr_lo;

  assign word           = bus.addr[31:2];
  assign unused_addr_lo = ^bus.addr[1:0];
  assign wr_th          = bus.wr && (word == WA_TH);
  assign wr_tl          = bus.wr && (word == WA_TL);
  assign wr_tcon        = bus.wr && (word == WA_TCON);
  assign wr_led         = bus.wr && (word == WA_LED);
  assign wr_digi        = bus.wr && (word == WA_DIGI);
  assign ovf            = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d      = wr_th ? bus.wdata : th_q;
    tl_d      = tl_q;
    tcon_d    = wr_tcon ? bus.wdata[2:0] : tcon_q;
    led_d     = wr_led ? bus.wdata[7:0] : led_q;
    digi_d    = wr_digi ? bus.wdata[11:0] : digi_q;
    sw_meta_d = switch;
    sw_sync_d = sw_meta_q;
    // A CPU write to TL overrides both the count and the reload, and suppresses the IRQ.
    if (wr_tl) begin
      tl_d = bus.wdata;
    end else if (ovf) begin
      tl_d = th_q;
    end else if (tcon_q[0]) begin
      tl_d = tl_q + 32'd1;
    end
    if (ovf && tcon_q[1] && !wr_tl) begin
      tcon_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q      <= TIMER_RESET_TH;
      tl_q      <= TIMER_RESET_TL;
      tcon_q    <= 3'b000;
      led_q     <= 8'h00;
      digi_q    <= 12'h000;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

`ifdef PERIPH_SYSTICK_EN
  localparam logic [29:0] WA_TICK = 30'h1000_0006;
  logic [31:0] systick_q, systick_d;

  assign systick_d = systick_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick_q <= 32'h0;
    end else begin
      systick_q <= systick_d;
    end
  end
`endif

  always_comb begin
    rdata_c = 32'h0;
    if (bus.rd) begin
      case (word)
        WA_TH:   rdata_c = th_q;
        WA_TL:   rdata_c = tl_q;
        WA_TCON: rdata_c = {29'h0, tcon_q};
        WA_LED:  rdata_c = {24'h0, led_q};
        WA_SW:   rdata_c = {24'h0, sw_sync_q};
        WA_DIGI: rdata_c = {20'h0, digi_q};
`ifdef PERIPH_SYSTICK_EN
        WA_TICK: rdata_c = systick_q;
`endif
        default: rdata_c = 32'h0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;
  assign led       = led_q;
  assign digi      = digi_q;
  assign irqout    = tcon_q[2];
endmodule

// File: tb/tb_periph_bus_slave.sv
// Bench for periph_bus_slave: directed test-plan steps plus a randomized phase against a register-file model.
module tb_periph_bus_slave;
  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;
  localparam logic [31:0] RST_T  = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw_pin;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  periph_bus_slave_if bus();

  periph_bus_slave #(.TIMER_RESET_TH(RST_T), .TIMER_RESET_TL(RST_T)) dut (
    .clk(clk), .reset(reset), .bus(bus), .switch(sw_pin),
    .led(led), .digi(digi), .irqout(irqout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: word offsets 0..7 from 0x4000_0000; switch history as a 2-deep queue; tick counts edges.
  logic [31:0] regs [0:7];
  logic [7:0]  sw_q [$];
  logic [31:0] tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int off);
    case (off)
      0, 1:    return 32'hFFFF_FFFF;
      2:       return 32'h7;
      3:       return 32'hFF;
      5:       return 32'hFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    int off;
    v = 32'h0;
    off = int'(a[4:2]);
    if (a[31:5] == 27'h200_0000) begin
      if (off == 4) v = {24'h0, sw_q[0]};
      else if (off == 6) begin
`ifdef PERIPH_SYSTICK_EN
        v = tick;
`endif
      end
      else if (off != 7) v = regs[off];
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) regs[i] = 32'h0;
    regs[0] = RST_T;
    regs[1] = RST_T;
    sw_q = '{8'h00, 8'h00};
    tick = 32'h0;
  endtask

  task automatic m_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] nxt [0:7];
    int off;
    logic mapped, hit;
    nxt = regs;
    off = int'(a[4:2]);
    mapped = (a[31:5] == 27'h200_0000);
    hit = regs[2][0] && (regs[1] == 32'hFFFF_FFFF);
    if (regs[2][0]) nxt[1] = hit ? regs[0] : regs[1] + 32'd1;
    if (w && mapped) nxt[off] = d & wmask(off);
    if (hit && regs[2][1] && !(w && mapped && off == 1)) nxt[2][2] = 1'b1;
    regs = nxt;
    sw_q.push_back(sw_pin);
    void'(sw_q.pop_front());
    tick = tick + 32'd1;
  endtask

  // One bus cycle: check the combinational read, take the edge, then check the registered outputs.
  task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = d;
    #1;
    chk("rdata", bus.rdata, r ? m_read(a) : 32'h0);
    @(posedge clk);
    m_edge(w, a, d);
    #1;
    chk("irqout", {31'h0, irqout}, {31'h0, regs[2][2]});
    chk("led", {24'h0, led}, regs[3]);
    chk("digi", {20'h0, digi}, regs[5]);
    bus.rd = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  initial begin
    logic [31:0] t0, a, d;
    int unsigned off;
    logic r, w;

    reset = 1'b1; sw_pin = 8'h00;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irqout", {31'h0, irqout}, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_digi", {20'h0, digi}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    reset = 1'b0;
    peek("rst_th", A_TH, 32'hFFFF_FC00);
    peek("rst_tl", A_TL, 32'hFFFF_FC00);
    peek("rst_tcon", A_TCON, 32'h0);

    // Overflow reload and IRQ
    cyc(0, 1, A_TH, 32'hFFFF_FFF0);
    cyc(0, 1, A_TL, 32'hFFFF_FFFE);
    cyc(0, 1, A_TCON, 32'h3);
    cyc(0, 0, A_TH, 32'h0);
    cyc(0, 0, A_TH, 32'h0);
    peek("ovf_tl_reload", A_TL, 32'hFFFF_FFF0);
    chk("ovf_irq_set", {31'h0, irqout}, 32'h1);
    cyc(0, 1, A_TCON, 32'h3);
    chk("irq_cleared", {31'h0, irqout}, 32'h0);
    peek("tl_continues", A_TL, 32'hFFFF_FFF1);

    // TCON write colliding with an overflow keeps the interrupt
    cyc(0, 1, A_TL, 32'hFFFF_FFFE);
    cyc(0, 0, A_TH, 32'h0);
    cyc(0, 1, A_TCON, 32'h1);
    peek("coll_tcon", A_TCON, 32'h5);
    chk("coll_irq", {31'h0, irqout}, 32'h1);
    cyc(1, 1, A_TCON, 32'h0);

    // LED, digi, switch
    cyc(0, 1, A_LED, 32'h1A5);
    chk("led_a5", {24'h0, led}, 32'hA5);
    peek("led_read", A_LED, 32'h0000_00A5);
    cyc(0, 1, A_DIGI, 32'hFFF);
    chk("digi_fff", {20'h0, digi}, 32'hFFF);
    sw_pin = 8'h3C;
    cyc(1, 0, A_SW, 32'h0);
    cyc(1, 0, A_SW, 32'h0);
    peek("sw_sync", A_SW, 32'h3C);

    // Unmapped addresses and strobes
    peek("unmapped_rd", 32'h4000_0020, 32'h0);
    cyc(0, 1, A_SW, 32'hFF);
    peek("sw_ro", A_SW, 32'h3C);
    bus.rd = 1'b0; bus.addr = A_TH;
    #1;
    chk("rd_low", bus.rdata, 32'h0);

    // SYSTICK
`ifdef PERIPH_SYSTICK_EN
    peek("tick0", A_TICK, tick);
    t0 = bus.rdata;
    repeat (10) cyc(0, 0, A_TH, 32'h0);
    peek("tick10", A_TICK, tick);
    chk("tick_delta", bus.rdata - t0, 32'd10);
`else
    peek("tick_absent", A_TICK, 32'h0);
`endif

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      off = $urandom_range(0, 8);
      a = 32'h4000_0000 + (off << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      if (off <= 1 && $urandom_range(0, 3) != 0) d = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else d = $urandom;
      r = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0);
      sw_pin = 8'($urandom);
      cyc(r, w, a, d);
    end

    // Asynchronous reset while counting with the IRQ raised
    cyc(0, 1, A_TCON, 32'h0);
    cyc(0, 1, A_LED, 32'h5A);
    cyc(0, 1, A_TL, 32'hFFFF_FFFF);
    cyc(0, 1, A_TCON, 32'h3);
    cyc(0, 0, A_TH, 32'h0);
    chk("pre_rst_irq", {31'h0, irqout}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_irq", {31'h0, irqout}, 32'h0);
    chk("async_led", {24'h0, led}, 32'h0);
    peek("async_th", A_TH, RST_T);
    peek("async_tcon", A_TCON, 32'h0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1, 0, A_TL, 32'h0);
    cyc(1, 0, A_TICK, 32'h0);
    cyc(1, 0, A_TICK, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
